// File: rtl/beam_pkg.sv
// Shared types and width helpers for the beam scan sequencer.
// Default geometry values live here so the top and benches agree on them.
package beam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        BLANK,
        ACQ,
        DRAIN,
        HOLD
    } beam_state_e;

    localparam int DEF_NUM_CHANNELS     = 4;
    localparam int DEF_NUM_LINES        = 64;
    localparam int DEF_SAMPLES_PER_LINE = 1024;
    localparam int DEF_BLANK_CYCLES     = 16;
    localparam int DEF_SUM_LATENCY      = 1;
    localparam int DEF_DELAY_WIDTH      = 8;

    // Field width that never collapses to zero for single-entry ranges.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_LINE_W = clog2w(DEF_NUM_LINES);
    localparam int DEF_SAMP_W = clog2w(DEF_SAMPLES_PER_LINE);
    localparam int DEF_CH_W   = clog2w(DEF_NUM_CHANNELS);
    localparam int DEF_ADDR_W = clog2w(DEF_NUM_LINES * DEF_NUM_CHANNELS);

endpackage

// File: rtl/beam_valid_pipe.sv
// Delays the capture enable by the summer latency so sum_valid lines up with
// the summer output; a flush empties it when a frame is abandoned.
module beam_valid_pipe
    import beam_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic flush_i,
    input  logic valid_i,
    output logic valid_o
);

    logic [DEPTH-1:0] pipe_q;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/beam_scan_ctrl.sv
// Per-line sequencer for the receive beamformer: delay load, transmit,
// blanking, sample capture and summer drain, repeated over a frame.
module beam_scan_ctrl
    import beam_pkg::*;
#(
    parameter  int NUM_CHANNELS     = DEF_NUM_CHANNELS,
    parameter  int NUM_LINES        = DEF_NUM_LINES,
    parameter  int SAMPLES_PER_LINE = DEF_SAMPLES_PER_LINE,
    parameter  int BLANK_CYCLES     = DEF_BLANK_CYCLES,
    parameter  int SUM_LATENCY      = DEF_SUM_LATENCY,
    parameter  int DELAY_WIDTH      = DEF_DELAY_WIDTH,
    localparam int ADDR_W           = clog2w(NUM_LINES * NUM_CHANNELS),
    localparam int CH_W             = clog2w(NUM_CHANNELS),
    localparam int LINE_W           = clog2w(NUM_LINES),
    localparam int SAMP_W           = clog2w(SAMPLES_PER_LINE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   line_hold,
    output logic [ADDR_W-1:0]      dly_rd_addr,
    input  logic [DELAY_WIDTH-1:0] dly_rd_data,
    output logic                   dly_wr_en,
    output logic [CH_W-1:0]        dly_wr_ch,
    output logic [DELAY_WIDTH-1:0] dly_wr_val,
    output logic                   tx_fire,
    output logic                   sample_en,
    output logic                   sum_valid,
    output logic [LINE_W-1:0]      line_idx,
    output logic [SAMP_W-1:0]      sample_idx,
    output logic                   line_done,
    output logic                   frame_done,
    output logic                   busy
);

    // One shared phase counter must reach the longest phase of any state.
    localparam int MAX_A   = (NUM_CHANNELS > BLANK_CYCLES) ? NUM_CHANNELS : BLANK_CYCLES;
    localparam int MAX_B   = (SAMPLES_PER_LINE > SUM_LATENCY) ? SAMPLES_PER_LINE : SUM_LATENCY;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = clog2w(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  LOAD_LAST  = CNT_W'(NUM_CHANNELS);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ACQ_LAST   = CNT_W'(SAMPLES_PER_LINE - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(SUM_LATENCY - 1);
    localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(NUM_LINES - 1);
    localparam logic [ADDR_W-1:0] CH_STRIDE  = ADDR_W'(NUM_CHANNELS);

    beam_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    line_d  = '0;
                end
            end
            LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = FIRE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIRE: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ACQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACQ: begin
                if (cnt_q == ACQ_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d = '0;
                    if (line_q == LINE_LAST) begin
                        state_d = IDLE;
                    end else if (line_hold) begin
                        state_d = HOLD;
                    end else begin
                        state_d = LOAD;
                        line_d  = line_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!line_hold) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    line_d  = line_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Abort wins over everything, including a simultaneous start in IDLE.
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            line_d  = line_q;
        end
    end

    // Table data returns one cycle after its address, so each write trails its read by one.
    always_comb begin
        dly_rd_addr = '0;
        dly_wr_en   = 1'b0;
        dly_wr_ch   = '0;
        dly_wr_val  = '0;
        tx_fire     = 1'b0;
        sample_en   = 1'b0;
        sample_idx  = '0;
        line_done   = 1'b0;
        frame_done  = 1'b0;
        busy        = (state_q != IDLE);
        case (state_q)
            LOAD: begin
                if (cnt_q < LOAD_LAST) begin
                    dly_rd_addr = ADDR_W'(line_q) * CH_STRIDE + ADDR_W'(cnt_q);
                end
                if (cnt_q != '0) begin
                    dly_wr_en  = 1'b1;
                    dly_wr_ch  = CH_W'(cnt_q - 1'b1);
                    dly_wr_val = dly_rd_data;
                end
            end
            FIRE: tx_fire = 1'b1;
            ACQ: begin
                sample_en  = 1'b1;
                sample_idx = SAMP_W'(cnt_q);
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST && !abort) begin
                    line_done  = 1'b1;
                    frame_done = (line_q == LINE_LAST);
                end
            end
            default: ;
        endcase
    end

    assign line_idx = line_q;

    beam_valid_pipe #(
        .DEPTH(SUM_LATENCY)
    ) u_valid_pipe (
        .clk    (clk),
        .reset  (reset),
        .flush_i(abort),
        .valid_i(sample_en),
        .valid_o(sum_valid)
    );

endmodule

// File: tb/tb_beam_scan_ctrl.sv
// Directed bench for beam_scan_ctrl on a small 4-channel, 2-line geometry
// with a synchronous delay-table model and an event monitor.
module tb_beam_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, abort, line_hold;
    logic [2:0] dly_rd_addr;
    logic [7:0] dly_rd_data;
    logic       dly_wr_en;
    logic [1:0] dly_wr_ch;
    logic [7:0] dly_wr_val;
    logic       tx_fire, sample_en, sum_valid;
    logic [0:0] line_idx;
    logic [2:0] sample_idx;
    logic       line_done, frame_done, busy;

    int testsRun = 0;
    int testsFailed = 0;
    int tickNo = 0;
    int loadTick = 0;

    int txCount = 0, sampleCount = 0, sumCount = 0, lineDoneCount = 0;
    int frameDoneCount = 0, wrCount = 0, alignErrors = 0;
    int txTick [0:31];
    logic [1:0] wrChLog  [0:63];
    logic [7:0] wrValLog [0:63];
    logic prevSampleEn = 1'b0;

    logic [7:0] romTable  [0:7];
    logic [7:0] expLine1  [0:3];

    beam_scan_ctrl #(
        .NUM_CHANNELS    (4),
        .NUM_LINES       (2),
        .SAMPLES_PER_LINE(8),
        .BLANK_CYCLES    (3),
        .SUM_LATENCY     (1),
        .DELAY_WIDTH     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .line_hold  (line_hold),
        .dly_rd_addr(dly_rd_addr),
        .dly_rd_data(dly_rd_data),
        .dly_wr_en  (dly_wr_en),
        .dly_wr_ch  (dly_wr_ch),
        .dly_wr_val (dly_wr_val),
        .tx_fire    (tx_fire),
        .sample_en  (sample_en),
        .sum_valid  (sum_valid),
        .line_idx   (line_idx),
        .sample_idx (sample_idx),
        .line_done  (line_done),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Synchronous delay table: data follows the address by one clock.
    always @(posedge clk) dly_rd_data <= romTable[dly_rd_addr];

    // Mid-cycle event log used for counts, write order and pulse spacing.
    always @(negedge clk) begin
        if (tx_fire === 1'b1) begin
            if (txCount < 32) txTick[txCount] = tickNo;
            txCount++;
        end
        if (sample_en === 1'b1) sampleCount++;
        if (sum_valid === 1'b1) sumCount++;
        if (line_done === 1'b1) lineDoneCount++;
        if (frame_done === 1'b1) frameDoneCount++;
        if (dly_wr_en === 1'b1) begin
            if (wrCount < 64) begin
                wrChLog[wrCount]  = dly_wr_ch;
                wrValLog[wrCount] = dly_wr_val;
            end
            wrCount++;
        end
        if (sum_valid !== prevSampleEn) alignErrors++;
        prevSampleEn = sample_en;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
        tickNo++;
    endtask

    task automatic applyStimulus(input logic st, input logic ab, input logic hold);
        start     = st;
        abort     = ab;
        line_hold = hold;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic startFrame();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        loadTick = tickNo;
    endtask

    task automatic waitFrameDone(input string tag);
        int budget = 0;
        while (frame_done !== 1'b1 && budget < 200) begin
            tick();
            budget++;
        end
        checkOutput(tag, 32'(frame_done), 1);
    endtask

    task automatic checkAllIdle(input string tag);
        checkOutput({tag, " busy"},        32'(busy), 0);
        checkOutput({tag, " tx_fire"},     32'(tx_fire), 0);
        checkOutput({tag, " sample_en"},   32'(sample_en), 0);
        checkOutput({tag, " sum_valid"},   32'(sum_valid), 0);
        checkOutput({tag, " dly_wr_en"},   32'(dly_wr_en), 0);
        checkOutput({tag, " dly_rd_addr"}, 32'(dly_rd_addr), 0);
        checkOutput({tag, " dly_wr_ch"},   32'(dly_wr_ch), 0);
        checkOutput({tag, " dly_wr_val"},  32'(dly_wr_val), 0);
        checkOutput({tag, " line_idx"},    32'(line_idx), 0);
        checkOutput({tag, " sample_idx"},  32'(sample_idx), 0);
        checkOutput({tag, " line_done"},   32'(line_done), 0);
        checkOutput({tag, " frame_done"},  32'(frame_done), 0);
    endtask

    initial begin
        int txBase, sampBase, sumBase, wrBase, ldBase, fdBase, alBase, budget;

        romTable[0] = 8'hA0; romTable[1] = 8'hA1; romTable[2] = 8'hA2; romTable[3] = 8'hA3;
        romTable[4] = 8'h11; romTable[5] = 8'h22; romTable[6] = 8'h33; romTable[7] = 8'h44;
        expLine1[0] = 8'h11; expLine1[1] = 8'h22; expLine1[2] = 8'h33; expLine1[3] = 8'h44;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkAllIdle("reset");
        reset = 1'b0;
        tick();

        // Nominal frame with a stray start in ACQ
        txBase = txCount; sampBase = sampleCount; sumBase = sumCount; wrBase = wrCount;
        ldBase = lineDoneCount; fdBase = frameDoneCount; alBase = alignErrors;
        startFrame();
        checkOutput("load0 busy", 32'(busy), 1);
        checkOutput("load0 addr", 32'(dly_rd_addr), 0);
        checkOutput("load0 wr_en", 32'(dly_wr_en), 0);
        for (int k = 1; k < 4; k++) begin
            tick();
            checkOutput("load addr", 32'(dly_rd_addr), 32'(k));
            checkOutput("load wr_en", 32'(dly_wr_en), 1);
            checkOutput("load wr_ch", 32'(dly_wr_ch), 32'(k - 1));
            checkOutput("load wr_val", 32'(dly_wr_val), 32'(romTable[k-1]));
        end
        tick();
        checkOutput("load4 wr_ch", 32'(dly_wr_ch), 3);
        checkOutput("load4 wr_val", 32'(dly_wr_val), 32'h A3);
        tick();
        checkOutput("fire tx_fire", 32'(tx_fire), 1);
        checkOutput("fire wr_en", 32'(dly_wr_en), 0);
        tick();
        checkOutput("blank tx_fire", 32'(tx_fire), 0);
        tick();
        tick();
        checkOutput("blank2 sample_en", 32'(sample_en), 0);
        tick();
        checkOutput("acq0 sample_en", 32'(sample_en), 1);
        checkOutput("acq0 sample_idx", 32'(sample_idx), 0);
        checkOutput("acq0 sum_valid", 32'(sum_valid), 0);
        tick();
        checkOutput("acq1 sum_valid", 32'(sum_valid), 1);
        checkOutput("acq1 sample_idx", 32'(sample_idx), 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitFrameDone("nominal frame_done seen");
        checkOutput("nominal frame_done cycle", 32'(tickNo - loadTick), 35);
        checkOutput("nominal line_done with frame", 32'(line_done), 1);
        checkOutput("nominal last line_idx", 32'(line_idx), 1);
        tick();
        checkOutput("nominal busy after frame", 32'(busy), 0);
        tick();
        tick();
        checkOutput("busy start not queued", 32'(busy), 0);
        checkOutput("nominal tx count", 32'(txCount - txBase), 2);
        checkOutput("nominal tx spacing", 32'(txTick[txBase+1] - txTick[txBase]), 18);
        checkOutput("nominal sample_en count", 32'(sampleCount - sampBase), 16);
        checkOutput("nominal sum_valid count", 32'(sumCount - sumBase), 16);
        checkOutput("nominal wr count", 32'(wrCount - wrBase), 8);
        checkOutput("nominal line_done count", 32'(lineDoneCount - ldBase), 2);
        checkOutput("nominal frame_done count", 32'(frameDoneCount - fdBase), 1);
        checkOutput("nominal sum alignment", 32'(alignErrors - alBase), 0);
        for (int c = 0; c < 4; c++) begin
            checkOutput("line1 wr_ch", 32'(wrChLog[wrBase+4+c]), 32'(c));
            checkOutput("line1 wr_val", 32'(wrValLog[wrBase+4+c]), 32'(expLine1[c]));
        end

        // Line hold for five cycles at the end of line 0
        txBase = txCount; alBase = alignErrors;
        startFrame();
        budget = 0;
        while (line_done !== 1'b1 && budget < 100) begin
            tick();
            budget++;
        end
        checkOutput("hold line0 done seen", 32'(line_done), 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int h = 0; h < 5; h++) tick();
        checkOutput("hold busy", 32'(busy), 1);
        checkOutput("hold line_idx", 32'(line_idx), 0);
        checkOutput("hold tx_fire", 32'(tx_fire), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("hold released line_idx", 32'(line_idx), 1);
        waitFrameDone("hold frame_done seen");
        checkOutput("hold frame_done cycle", 32'(tickNo - loadTick), 40);
        tick();
        checkOutput("hold tx spacing", 32'(txTick[txBase+1] - txTick[txBase]), 23);
        checkOutput("hold sum alignment", 32'(alignErrors - alBase), 0);

        // Abort in ACQ at sample 3
        txBase = txCount; ldBase = lineDoneCount; fdBase = frameDoneCount;
        startFrame();
        budget = 0;
        while (!(sample_en === 1'b1 && sample_idx === 3'd3) && budget < 100) begin
            tick();
            budget++;
        end
        checkOutput("abort reached sample 3", 32'(sample_idx), 3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort sample_en", 32'(sample_en), 0);
        checkOutput("abort busy", 32'(busy), 0);
        checkOutput("abort sum_valid", 32'(sum_valid), 0);
        tick();
        tick();
        checkOutput("abort no line_done", 32'(lineDoneCount - ldBase), 0);
        checkOutput("abort no frame_done", 32'(frameDoneCount - fdBase), 0);
        checkOutput("abort tx count", 32'(txCount - txBase), 1);

        // Start together with abort in IDLE
        txBase = txCount;
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("start+abort busy", 32'(busy), 0);
        tick();
        tick();
        checkOutput("start+abort tx count", 32'(txCount - txBase), 0);

        // Reset in the middle of BLANK, then a clean frame
        startFrame();
        for (int t = 0; t < 7; t++) tick();
        checkOutput("mid-blank busy", 32'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkAllIdle("mid-blank reset");
        tick();
        txBase = txCount; sampBase = sampleCount; wrBase = wrCount;
        startFrame();
        waitFrameDone("post-reset frame_done seen");
        checkOutput("post-reset frame_done cycle", 32'(tickNo - loadTick), 35);
        tick();
        checkOutput("post-reset busy", 32'(busy), 0);
        checkOutput("post-reset tx count", 32'(txCount - txBase), 2);
        checkOutput("post-reset sample_en count", 32'(sampleCount - sampBase), 16);
        checkOutput("post-reset wr count", 32'(wrCount - wrBase), 8);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
